// File: rtl/mt9v032_tx_model.sv
// ---------------------------------------------------------------------------
// mt9v032_tx_model
//
// Emulates the serial stream an MT9V032 sensor drives in embedded-sync mode.
// Every 12-bit packet is: start bit 1, data D0..D9 (LSB first), stop bit 0.
// Frames are V_ACTIVE active lines followed by V_BLANK blank lines. Each line
// is H_ACTIVE + H_BLANK words long. Active lines carry sync codes around the
// pixel payload. Everything runs on the serial bit clock, one bit per cycle.
//
// Ports
//   clk          serial bit clock (12x word rate)
//   rst          asynchronous active-high reset
//   en           frame enable, sampled only at a frame boundary
//   px_in        external pixel, captured one cycle after px_req
//   px_req       one-cycle strobe asking for the next pixel
//   tx_out       registered serial data (inverted when SWAP=1)
//   frame_active high from the frame-start word through the last blank word
//   frame_count  completed frames, wraps 16'hFFFF -> 0
//   dbg_state    current FSM state (IDLE=0, ACTIVE_LINE=1, BLANK_LINE=2)
//
// Pixel handshake: px_req is high for exactly one cycle (bit_cnt==10) in the
// word before each pixel word. The source must present px_in by the end of
// the following cycle (bit_cnt==11); it is sampled on that clock edge. There
// is no back-pressure. A pixel is requested whenever the stream needs one.
// ---------------------------------------------------------------------------
module mt9v032_tx_model #(
    parameter int   H_ACTIVE = 752,
    parameter int   H_BLANK  = 94,
    parameter int   V_ACTIVE = 480,
    parameter int   V_BLANK  = 45,
    parameter logic SWAP     = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [9:0]  px_in,
    output logic        px_req,
    output logic        tx_out,
    output logic        frame_active,
    output logic [15:0] frame_count,
    output logic [1:0]  dbg_state
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int L_TOTAL = V_ACTIVE + V_BLANK;
    localparam int WW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int LW      = (L_TOTAL > 1) ? $clog2(L_TOTAL) : 1;

    localparam logic [WW-1:0] WC_LAST      = WW'(H_TOTAL - 1);
    localparam logic [WW-1:0] WC_ONE       = WW'(1);
    localparam logic [WW-1:0] WC_REQ_FIRST = WW'(2);
    localparam logic [WW-1:0] WC_PX_FIRST  = WW'(3);
    localparam logic [WW-1:0] WC_REQ_LAST  = WW'(H_ACTIVE + 1);
    localparam logic [WW-1:0] WC_PX_LAST   = WW'(H_ACTIVE + 2);
    localparam logic [WW-1:0] WC_END_FIRST = WW'(H_ACTIVE + 3);
    localparam logic [WW-1:0] WC_END_LAST  = WW'(H_ACTIVE + 5);
    localparam logic [LW-1:0] LC_VA_LAST   = LW'(V_ACTIVE - 1);
    localparam logic [LW-1:0] LC_LAST      = LW'(L_TOTAL - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_BLANK  = 2'd2;

    logic [1:0]    r_state;
    logic [WW-1:0] r_word_cnt;
    logic [LW-1:0] r_line_cnt;
    logic [3:0]    r_bit_cnt;
    logic [11:0]   r_shreg;
    logic          r_tx;
    logic          r_px_req;
    logic          r_frame_active;
    logic [15:0]   r_frame_count;

    logic          w_wrap;
    logic [1:0]    w_nxt_state;
    logic [WW-1:0] w_nxt_word;
    logic [LW-1:0] w_nxt_line;
    logic          w_frame_done;
    logic [9:0]    w_px_clamped;
    logic [9:0]    w_word;
    logic [WW-1:0] w_off;
    logic          w_next_is_px;

    assign w_wrap = (r_bit_cnt == 4'd11);

    // Position of the word that will be loaded at the next word boundary.
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_word   = r_word_cnt;
        w_nxt_line   = r_line_cnt;
        w_frame_done = 1'b0;
        if (r_state == S_IDLE) begin
            if (en) begin
                w_nxt_state = S_ACTIVE;
                w_nxt_word  = '0;
                w_nxt_line  = '0;
            end
        end else if (r_word_cnt == WC_LAST) begin
            w_nxt_word = '0;
            if (r_line_cnt == LC_LAST) begin
                // End of the last blank line: en decides back-to-back or idle.
                w_frame_done = 1'b1;
                w_nxt_line   = '0;
                w_nxt_state  = en ? S_ACTIVE : S_IDLE;
            end else begin
                w_nxt_line = r_line_cnt + 1'b1;
                if (r_line_cnt == LC_VA_LAST) begin
                    w_nxt_state = S_BLANK;
                end
            end
        end else begin
            w_nxt_word = r_word_cnt + 1'b1;
        end
    end

    // Reserved codes 0x000/0x3FF are pulled one step inward.
    always_comb begin
        w_px_clamped = px_in;
        if (px_in == 10'h000) begin
            w_px_clamped = 10'h001;
        end else if (px_in == 10'h3FF) begin
            w_px_clamped = 10'h3FE;
        end
    end

    // Data content of the next word.
    always_comb begin
        w_word = 10'h000;
        w_off  = w_nxt_word - WC_END_FIRST;
        if (w_nxt_state == S_ACTIVE) begin
            if (w_nxt_word < WC_PX_FIRST) begin
                if (w_nxt_line == '0) begin
                    // frame start 3FF,000,3FF
                    w_word = (w_nxt_word == WC_ONE) ? 10'h000 : 10'h3FF;
                end else begin
                    // line start 000,3FF,000
                    w_word = (w_nxt_word == WC_ONE) ? 10'h3FF : 10'h000;
                end
            end else if (w_nxt_word <= WC_PX_LAST) begin
                w_word = w_px_clamped;
            end else if (w_nxt_word <= WC_END_LAST) begin
                if (w_nxt_line == LC_VA_LAST) begin
                    // frame end 3FF,000,000
                    w_word = (w_off == '0) ? 10'h3FF : 10'h000;
                end else begin
                    // line end 000,3FF,3FF
                    w_word = (w_off == '0) ? 10'h000 : 10'h3FF;
                end
            end
        end
    end

    // The word after the current one is a pixel only inside an active line,
    // so it never depends on en or on a line/frame transition.
    assign w_next_is_px = (r_state == S_ACTIVE) &&
                          (r_word_cnt >= WC_REQ_FIRST) &&
                          (r_word_cnt <= WC_REQ_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_word_cnt     <= '0;
            r_line_cnt     <= '0;
            r_bit_cnt      <= 4'd0;
            r_shreg        <= 12'h001;  // blank packet: start bit in bit 0
            r_tx           <= SWAP;
            r_px_req       <= 1'b0;
            r_frame_active <= 1'b0;
            r_frame_count  <= 16'h0000;
        end else begin
            r_tx     <= r_shreg[0] ^ SWAP;
            r_px_req <= (r_bit_cnt == 4'd9) && w_next_is_px;
            // Updated on the same edge that puts the start bit on tx_out,
            // so frame_active is aligned with whole words of the stream.
            if (r_bit_cnt == 4'd0) begin
                r_frame_active <= (r_state != S_IDLE);
            end
            if (w_wrap) begin
                r_bit_cnt  <= 4'd0;
                r_shreg    <= {1'b0, w_word, 1'b1};
                r_state    <= w_nxt_state;
                r_word_cnt <= w_nxt_word;
                r_line_cnt <= w_nxt_line;
                if (w_frame_done) begin
                    r_frame_count <= r_frame_count + 16'd1;
                end
            end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
                r_shreg   <= {1'b0, r_shreg[11:1]};
            end
        end
    end

    assign tx_out       = r_tx;
    assign px_req       = r_px_req;
    assign frame_active = r_frame_active;
    assign frame_count  = r_frame_count;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_mt9v032_tx_model.sv
// ---------------------------------------------------------------------------
// tb_mt9v032_tx_model
//
// Drives two instances (SWAP=0 and SWAP=1) of a small configuration
// (4 px, 8 blank words, 2 active lines, 1 blank line). The bench deserialises
// tx_out word by word and compares each word against a hand-written frame
// table. It also checks px_req, frame_active, frame_count and the SWAP
// inversion.
// ---------------------------------------------------------------------------
module tb_mt9v032_tx_model;

    localparam int HA = 4;
    localparam int HB = 8;
    localparam int VA = 2;
    localparam int VB = 1;
    localparam int NW = (HA + HB) * (VA + VB);  // 36 words per frame

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [9:0]  px_in = 10'h000;

    logic        tx0, tx1, req0, req1, fa0, fa1;
    logic [15:0] fc0, fc1;
    logic [1:0]  st0, st1;

    mt9v032_tx_model #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
                       .SWAP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .px_in(px_in),
        .px_req(req0), .tx_out(tx0), .frame_active(fa0),
        .frame_count(fc0), .dbg_state(st0)
    );

    mt9v032_tx_model #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
                       .SWAP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .px_in(px_in),
        .px_req(req1), .tx_out(tx1), .frame_active(fa1),
        .frame_count(fc1), .dbg_state(st1)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    // ---------------- expected frame table ----------------
    typedef struct {
        logic       is_px;   // word carries a pixel from px_in
        logic [9:0] code;    // fixed code when not a pixel
        logic       nxt_px;  // a px_req is expected during this word
    } vec_t;

    vec_t vec[NW];

    // -1 marks a pixel slot
    int line0_t[12] = '{'h3FF, 0, 'h3FF, -1, -1, -1, -1, 0, 'h3FF, 'h3FF, 0, 0};
    int line1_t[12] = '{0, 'h3FF, 0, -1, -1, -1, -1, 'h3FF, 0, 0, 0, 0};

    int   n_checks = 0;
    int   n_fail   = 0;
    int   px_mode  = 0;      // 0: constant 0x155, 1: alternate 0x000/0x3FF
    logic px_tog   = 1'b0;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Capture one 12-bit packet, sampling on the falling edge.
    task automatic cap_word(input string name, input logic [9:0] exp_word,
                            input logic exp_fa, input logic exp_req,
                            input logic [15:0] exp_fc);
        logic [11:0] bits;
        int req_cnt = 0;
        int req_bad = 0;
        int fa_bad  = 0;
        int sw_bad  = 0;
        bits = '0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            bits[j] = tx0;
            if (tx1 !== ~tx0) sw_bad++;
            if ({req1, fa1, fc1, st1} !== {req0, fa0, fc0, st0}) sw_bad++;
            if (fa0 !== exp_fa) fa_bad++;
            if (j == 0) check({name, " frame_count"}, 32'(fc0), 32'(exp_fc));
            if (req0 === 1'b1) begin
                req_cnt++;
                if (j != 9) req_bad++;
                if (px_mode == 1) begin
                    px_in  = px_tog ? 10'h3FF : 10'h000;
                    px_tog = ~px_tog;
                end
            end
        end
        check({name, " packet"}, 32'(bits), 32'({1'b0, exp_word, 1'b1}));
        check({name, " px_req count"}, 32'(req_cnt), 32'(exp_req));
        check({name, " px_req position errs"}, 32'(req_bad), 32'd0);
        check({name, " frame_active errs"}, 32'(fa_bad), 32'd0);
        check({name, " swap errs"}, 32'(sw_bad), 32'd0);
    endtask

    // One complete frame. en stays high for words [0, drop_at).
    task automatic run_frame(input string tag, input int mode, input int drop_at,
                             input logic [15:0] fc_before);
        int pix = 0;
        logic [9:0] exp;
        px_mode = mode;
        px_tog  = 1'b0;
        if (mode == 0) px_in = 10'h155;
        for (int i = 0; i < NW; i++) begin
            en = (i < drop_at);
            if (vec[i].is_px) begin
                if (mode == 0) exp = 10'h155;
                else exp = (pix % 2 == 0) ? 10'h001 : 10'h3FE;
                pix++;
            end else begin
                exp = vec[i].code;
            end
            cap_word($sformatf("%s w%0d", tag, i), exp, 1'b1, vec[i].nxt_px,
                     fc_before);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        for (int i = 0; i < NW; i++) begin
            int src;
            src = (i < 12) ? line0_t[i] : (i < 24) ? line1_t[i - 12] : 0;
            vec[i].is_px = (src < 0);
            vec[i].code  = (src < 0) ? 10'h000 : src[9:0];
        end
        for (int i = 0; i < NW; i++) begin
            vec[i].nxt_px = (i + 1 < NW) ? vec[i + 1].is_px : 1'b0;
        end

        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset tx_out swap0", 32'(tx0), 32'd0);
        check("reset tx_out swap1", 32'(tx1), 32'd1);
        check("reset px_req", 32'(req0), 32'd0);
        check("reset frame_active", 32'(fa0), 32'd0);
        check("reset frame_count", 32'(fc0), 32'd0);
        check("reset state", 32'(st0), 32'd0);
        rst = 1'b0;

        // en=0: blank packets only
        for (int i = 0; i < 4; i++) begin
            cap_word($sformatf("idle%0d", i), 10'h000, 1'b0, 1'b0, 16'd0);
        end

        // en raised during an idle word: frame starts with the next word
        en = 1'b1;
        cap_word("idle pre-f1", 10'h000, 1'b0, 1'b0, 16'd0);
        run_frame("f1", 0, NW, 16'd0);
        // back-to-back, clamp test, en dropped mid-frame
        run_frame("f2", 1, 10, 16'd1);
        cap_word("idle post-f2 a", 10'h000, 1'b0, 1'b0, 16'd2);
        cap_word("idle post-f2 b", 10'h000, 1'b0, 1'b0, 16'd2);

        // reset in the middle of a pixel word
        px_mode = 0;
        px_in   = 10'h155;
        en      = 1'b1;
        cap_word("idle pre-f3", 10'h000, 1'b0, 1'b0, 16'd2);
        for (int i = 0; i < 4; i++) begin
            cap_word($sformatf("f3 w%0d", i),
                     vec[i].is_px ? 10'h155 : vec[i].code, 1'b1, vec[i].nxt_px,
                     16'd2);
        end
        for (int j = 0; j < 6; j++) @(negedge clk);
        check("pre-reset tx bit5 of 0x155", 32'(tx0), 32'd1);
        rst = 1'b1;
        #1;
        check("async reset tx_out swap0", 32'(tx0), 32'd0);
        check("async reset tx_out swap1", 32'(tx1), 32'd1);
        check("async reset frame_count", 32'(fc0), 32'd0);
        check("async reset frame_active", 32'(fa0), 32'd0);
        check("async reset state", 32'(st0), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // restart: one idle word, then a frame from the frame-start code
        cap_word("idle post-reset", 10'h000, 1'b0, 1'b0, 16'd0);
        run_frame("f4", 0, NW, 16'd0);
        en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mt9v032_tx_model.md
Name: mt9v032_tx_model

Overview:
- Transmit-side counterpart of the MT9V032 LVDS receive path. Generates the serial stream an MT9V032 sensor drives in embedded-sync mode.
- Stream structure: 12-bit packets carrying 10-bit words, with frame/line sync codes, blanking, and pixel payload.
- Uses: loopback source for the camera serdes/post chain in simulation and on-board self-test, and sensor emulation when no camera is fitted.
- Runs entirely on the serial bit clock: one output bit per cycle.

Parameters:
- H_ACTIVE, 752: active pixels per line (>=1).
- H_BLANK, 94: non-pixel words per line, sync codes included (>=6).
- V_ACTIVE, 480: active lines per frame (>=1).
- V_BLANK, 45: blank lines per frame (>=1).
- SWAP, 1'b0: 1 inverts tx_out (board P/N swap).

Ports:
- clk, input, 1: serial bit clock (12x word rate).
- rst, input, 1: asynchronous active-high reset.
- en, input, 1: frame enable, sampled only at frame boundary.
- px_in, input, 10: external pixel value, sampled one cycle after px_req.
- px_req, output, 1: one-cycle strobe requesting next pixel.
- tx_out, output, 1: registered serial data to LVDS output buffer.
- frame_active, output, 1: high from first word of frame-start code through last word of final blank line.
- frame_count, output, 16: completed frames, wraps at 16'hFFFF->0.

Behaviour:
- Packet format, 12 bits, first bit out first:
  - start bit 1;
  - data bits D0..D9, LSB first;
  - stop bit 0.
- bit_cnt runs 0..11 continuously. The next word is loaded when bit_cnt wraps 11->0. tx_out = current packet bit ^ SWAP, registered.
- Reset values: tx_out=SWAP, px_req=0, frame_active=0, frame_count=0, bit_cnt=0; state IDLE.
- Output latency: the first start bit appears in the 2nd cycle after rst deasserts.
- States: IDLE, ACTIVE_LINE, BLANK_LINE. word_cnt runs 0..H_ACTIVE+H_BLANK-1; line_cnt runs 0..V_ACTIVE+V_BLANK-1.
- IDLE:
  - emits blanking word 0x000 continuously;
  - at each word boundary, if en=1, enters ACTIVE_LINE with line_cnt=0 and word_cnt=0.
- ACTIVE_LINE word layout:
  - words 0-2: line start code 0x000,0x3FF,0x000. On line 0 the frame start code 0x3FF,0x000,0x3FF is used instead.
  - words 3..H_ACTIVE+2: pixels.
  - next 3 words: line end code 0x000,0x3FF,0x3FF. On line V_ACTIVE-1 the frame end code 0x3FF,0x000,0x000 is used instead.
  - remaining words to end of line: 0x000.
- BLANK_LINE: all H_ACTIVE+H_BLANK words are 0x000.
- Line sequencing:
  - after the last word of a line, line_cnt increments;
  - line_cnt=V_ACTIVE enters BLANK_LINE;
  - after the last blank line, frame_count increments and the frame ends.
- Frame end:
  - if en=1 at that word boundary, the next frame starts immediately with no IDLE word;
  - otherwise the block enters IDLE.
- en deasserted mid-frame has no effect; the frame always completes.
- Pixel handshake:
  - px_req pulses in the cycle bit_cnt==10 of the word preceding each pixel word;
  - px_in is captured at the end of the bit_cnt==11 cycle;
  - exactly H_ACTIVE px_req pulses per active line, none elsewhere.
- Pixel clamp: reserved codes never appear as pixels. px_in 0x000 is sent as 0x001; px_in 0x3FF is sent as 0x3FE.
- frame_active:
  - rises in the cycle tx_out carries the start bit of frame-start word 0;
  - falls after the stop bit of the last blank-line word, unless the next frame starts back to back, in which case it stays high.
- rst mid-packet aborts immediately. tx_out returns to SWAP, and the stream restarts in IDLE at a packet boundary.

Test Plan:
- Small config H_ACTIVE=4, H_BLANK=8, V_ACTIVE=2, V_BLANK=1; rst released, en=0 -> continuous packets 1,0000000000,0 (bit pattern 100000000000 repeating); px_req never asserts; frame_count=0.
- Same config, en=1, px_in=0x155 -> deserialized word sequence:
  - line 0: 3FF,000,3FF, four 155s, 000,3FF,3FF, then 000 x2;
  - line 1: 000,3FF,000, four 155s, 3FF,000,000, then 000 x2;
  - blank line: twelve 000.
  - frame is 432 clk cycles; frame_count=1 afterwards.
- px_in driven 0x000 then 0x3FF on alternate px_req -> transmitted pixels 0x001 and 0x3FE alternately; exactly 4 px_req per active line, each 12 cycles apart.
- en=1 for one frame then dropped at mid-frame -> frame completes with all 36 words; frame_count=1; IDLE zeros follow; frame_active falls after the last blank word.
- SWAP=1, looped through mt9v032_serdes and mt9v032_post instances with the matching SWAP bit -> receiver reports line_valid for exactly 4 px per line, 2 lines per frame, px values equal to the clamped px_in.
- rst asserted at bit_cnt=5 of a pixel word -> tx_out=SWAP within the same cycle (async); after release, the next frame begins with the frame start code; frame_count=0.
